iter_mult: RTL
==============

# iter_mult

Parametrised iterative shift-add multiplier with a valid/ready handshake on both sides. It is the sequential, area-lean member of the multiplier family. It retires one multiplier bit per clock, supports unsigned and two's-complement signed operands selected per transaction, and holds its result until the consumer accepts it. Defaults (W1=3, W2=4) match the smallest combinational generated multiplier, so both can be dropped into the same datapath slot.

## Interface
- W1, 3, width of operand A (multiplicand); legal range ≥2
- W2, 4, width of operand B (multiplier); legal range ≥2; sets iteration count
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands this cycle
- in_a  in  W1  multiplicand
- in_b  in  W2  multiplier
- in_signed  in  1  1 = both operands two's complement; 0 = both unsigned
- out_valid  out  1  product available
- out_ready  in  1  consumer takes product this cycle
- out_p  out  W1+W2  exact product

## Operation
- States:
  - IDLE: waits for operands.
  - BUSY: iterates.
  - DONE: holds the result.
- Accept: a transaction is accepted on an edge where in_valid & in_ready.
  - On accept, register in_a, in_b, in_signed; clear accumulator and counter cnt; go BUSY.
- in_ready = !rst & (IDLE | (DONE & out_ready)). It is combinational on state and out_ready.
- BUSY, each edge:
  - If b[cnt]=1, add the partial product to the accumulator: (a extended to W1+W2 bits) << cnt.
  - Extension is sign-extension if the latched signed flag is 1, zero-extension otherwise.
  - Signed mode with cnt = W2-1: the partial product is subtracted instead of added (weight −2^(W2−1)).
  - cnt increments. On the edge where cnt = W2-1, go DONE.
- Arithmetic: the accumulator is W1+W2 bits, and addition/subtraction is modulo 2^(W1+W2). The final value is the exact product for every operand pair in both modes, so no overflow is possible.
- DONE:
  - out_valid=1; out_p = accumulator, held stable until handshake.
  - out_ready=1 and in_valid=0: go IDLE.
  - out_ready=1 and in_valid=1: the result retires and the new operands are accepted on the same edge; go BUSY (back-to-back).
  - out_ready=0: remain DONE; out_p, out_valid unchanged.
- in_a/in_b/in_signed are ignored outside the accept edge. Changes during BUSY have no effect.
- Reset values: state IDLE, out_valid 0, out_p 0, cnt 0, accumulator 0. in_ready is 0 while rst=1 and 1 on the first cycle after rst deasserts.
- Reset mid-operation (BUSY or DONE): the transaction is discarded, with no out_valid pulse for it; the block is in IDLE on the next cycle.

## Timing
- Latency: out_valid rises W2 edges after the accepting edge (W2=4: accept at edge 0, out_valid high after edge 4).
- Throughput:
  - With out_ready held 1 and back-to-back issue: one result per W2+1 cycles (W2 BUSY + 1 DONE cycle).
  - Via IDLE: W2+2 cycles.
- out_valid is registered. out_p is registered and changes only on entering DONE or on reset.
- in_ready is low throughout BUSY and throughout DONE while out_ready=0.
- No combinational path from in_* to out_*. The only comb path is out_ready → in_ready.

## Test plan
- Unsigned max, W1=3/W2=4: a=7, b=15, signed=0 → out_valid rises exactly 4 edges after accept; out_p=7'h69 (105).
- Signed corners: (a=3'b100, b=4'b0111, signed=1) → out_p=7'h64 (−28); (a=3'b100, b=4'b1000) → 7'h20 (+32); (a=3'b111, b=4'b1111) → 7'h01.
- Exhaustive: all 128 (a, b) pairs × both modes with random in_valid/out_ready gaps → every out_p matches a behavioural model, in issue order, none lost or duplicated.
- Backpressure: result 7'h69 in DONE, out_ready=0 for 6 cycles → out_p/out_valid stable and in_ready=0 throughout; out_ready=1 → retires in one cycle.
- Back-to-back: in DONE with out_ready=1 and in_valid=1 (a=2, b=3) → accepted same edge, out_valid low for 4 cycles, then out_p=7'h06.
- Reset mid-BUSY at cnt=2 → next cycle state IDLE, out_valid=0, out_p=0, in_ready=1; the aborted result never appears.

Source files
------------

// File: rtl/iter_mult.sv
// rtl/iter_mult.sv - iterative shift-add multiplier, one multiplier bit per clock
// Unsigned or two's-complement per transaction; result held until the consumer takes it.
module iter_mult #(
  parameter int W1 = 3,
  parameter int W2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W1-1:0]     in_a,
  input  logic [W2-1:0]     in_b,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W1+W2-1:0]  out_p
);

  localparam int W  = W1 + W2;
  localparam int CW = (W2 > 1) ? $clog2(W2) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W2 - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [W1-1:0] a_q;
  logic [W2-1:0] b_q;
  logic          sgn_q;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last;
  logic [W-1:0]  a_ext;
  logic [W-1:0]  pp;
  logic [W-1:0]  acc_nxt;

  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CNT_LAST);

  // The top multiplier bit carries weight -2^(W2-1) in signed mode, hence the subtract.
  always_comb begin
    a_ext   = sgn_q ? {{W2{a_q[W1-1]}}, a_q} : {{W2{1'b0}}, a_q};
    pp      = a_ext << cnt;
    acc_nxt = acc;
    if (b_q[cnt]) begin
      acc_nxt = (sgn_q && last) ? (acc - pp) : (acc + pp);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_p     <= '0;
      cnt       <= '0;
      acc       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q       <= in_a;
        b_q       <= in_b;
        sgn_q     <= in_signed;
        acc       <= '0;
        cnt       <= '0;
        out_valid <= 1'b0;
      end else if (state == BUSY) begin
        acc <= acc_nxt;
        cnt <= last ? '0 : (cnt + CW'(1));
        if (last) begin
          out_p     <= acc_nxt;
          out_valid <= 1'b1;
        end
      end else if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
